// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master controller: FSM encodings and mode helpers.
package spi_pkg;

  // One-hot controller states
  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_SETUP = 5'b00010,
    ST_XFER  = 5'b00100,
    ST_HOLD  = 5'b01000,
    ST_DONE  = 5'b10000
  } state_e;

  // SPI modes packed as {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // Clock idle level of a packed mode
  function automatic logic mode_cpol(input logic [1:0] mode);
    return mode[1];
  endfunction

  // 1 when data is sampled on the trailing sclk edge
  function automatic logic mode_cpha(input logic [1:0] mode);
    logic cpha;
    case (mode)
      SPI_MODE0, SPI_MODE2: cpha = 1'b0;
      SPI_MODE1, SPI_MODE3: cpha = 1'b1;
      default:              cpha = mode[0];
    endcase
    return cpha;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SPI bit-clock generator: half-period down-counter with terminal-count toggle of sclk.
// While disabled the counter is preloaded with div and sclk parks at cpol, so the
// first edge after enable arrives exactly div+1 cycles later.
module spi_clk_gen #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 cpol,
  output logic                 sclk,
  output logic                 edge_stb,
  output logic                 edge_lead
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 sclk_q, sclk_d;

  // Next-state for the half-period counter and sclk level
  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en) begin
      cnt_d  = div;
      sclk_d = cpol;
    end else if (cnt_q == '0) begin
      cnt_d  = div;
      sclk_d = ~sclk_q;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter and sclk registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  // The strobe marks the clk edge on which sclk toggles; a leading edge moves sclk away from idle
  assign edge_stb  = en && (cnt_q == '0);
  assign edge_lead = (sclk_q == cpol);
  assign sclk      = sclk_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master transaction sequencer: accepts one command, runs the SPI frame and
// returns the received word on a valid/ready response port.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | cs_n high, sclk at latched cpol, cmd_ready high
// ST_SETUP | cs_n low, mosi = bit0, sclk = cpol, div+1 cycles
// ST_XFER  | 2*(len+1) sclk edges, one every div+1 cycles
// ST_HOLD  | sclk back at cpol, cs_n still low, div+1 cycles
// ST_DONE  | cs_n high, rsp_valid high until rsp_ready
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int DLY        = 1,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = $clog2(DATA_WIDTH),
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic                  cmd_cpol,
  input  logic                  cmd_cpha,
  input  logic [DIV_WIDTH-1:0]  cmd_div,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy,
  output logic                  spi_cs_n,
  output logic                  spi_sclk,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(DATA_WIDTH - 1);

  // DLY is kept so existing instantiations still elaborate; this RTL is zero-delay.
  logic dly_unused;
  assign dly_unused = (DLY != 0);

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [1:0]            mode_q, mode_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [DIV_WIDTH-1:0]  tmr_q, tmr_d;
  logic [LEN_WIDTH:0]    bits_left_q, bits_left_d;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  busy_q, busy_d;
  logic                  cs_n_q, cs_n_d;
  logic                  mosi_q, mosi_d;

  logic                  edge_stb;
  logic                  edge_lead;
  logic                  cpha;
  logic [LEN_WIDTH-1:0]  shamt;

  assign cpha  = mode_cpha(mode_q);
  assign shamt = LEN_MAX - len_q;

  // sclk sees the next-cycle cpol so it already sits at the new idle level during SETUP
  spi_clk_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_clk_gen (
    .clk       (clk),
    .rst       (rst),
    .en        (state_q == ST_XFER),
    .div       (div_q),
    .cpol      (mode_cpol(mode_d)),
    .sclk      (spi_sclk),
    .edge_stb  (edge_stb),
    .edge_lead (edge_lead)
  );

  // Sequencer next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    mode_d      = mode_q;
    div_d       = div_q;
    tmr_d       = tmr_q;
    bits_left_d = bits_left_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    cs_n_d      = cs_n_q;
    mosi_d      = mosi_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d     = ST_SETUP;
          len_d       = cmd_len;
          mode_d      = {cmd_cpol, cmd_cpha};
          div_d       = cmd_div;
          tmr_d       = cmd_div;
          bits_left_d = {1'b0, cmd_len};
          tx_sr_d     = cmd_data;
          rx_sr_d     = '0;
          mosi_d      = cmd_data[0];
          cs_n_d      = 1'b0;
        end
      end

      ST_SETUP: begin
        if (tmr_q == '0) begin
          state_d = ST_XFER;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end

      ST_XFER: begin
        if (edge_stb) begin
          if (edge_lead) begin
            if (!cpha) begin
              rx_sr_d = {spi_miso, rx_sr_q[DATA_WIDTH-1:1]};
            end else begin
              // The first leading edge re-drives bit0, so mosi is never ahead of the slave
              mosi_d  = tx_sr_q[0];
              tx_sr_d = tx_sr_q >> 1;
            end
          end else begin
            if (cpha) begin
              rx_sr_d = {spi_miso, rx_sr_q[DATA_WIDTH-1:1]};
            end
            if (bits_left_q == '0) begin
              state_d = ST_HOLD;
              tmr_d   = div_q;
            end else begin
              bits_left_d = bits_left_q - 1'b1;
              if (!cpha) begin
                mosi_d  = tx_sr_q[1];
                tx_sr_d = tx_sr_q >> 1;
              end
            end
          end
        end
      end

      ST_HOLD: begin
        if (tmr_q == '0) begin
          state_d     = ST_DONE;
          cs_n_d      = 1'b1;
          mosi_d      = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = rx_sr_q >> shamt;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end

      ST_DONE: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cs_n_d      = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  // Sequencer state and output registers; reset aborts any frame with no response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      mode_q      <= SPI_MODE0;
      div_q       <= '0;
      tmr_q       <= '0;
      bits_left_q <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      div_q       <= div_d;
      tmr_q       <= tmr_d;
      bits_left_q <= bits_left_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      cs_n_q      <= cs_n_d;
      mosi_q      <= mosi_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign spi_cs_n  = cs_n_q;
  assign spi_mosi  = mosi_q;

endmodule
